jp_responder: RTL and testbench
===============================

// Module: jp_responder
// PURPOSE
//  Controller-side end of the NES joypad serial link: emulates a 4021-based standard pad.
//  Samples latch/clock driven by a host console (external NES or second DragonBoard) and returns
//  8 button bits on the data line. Button sources: debounced board buttons or a decoded USB/I2C report.
//  Adds input filtering, optional turbo on A/B and opposing-direction masking.
// PARAMETERS
//  FILT_CYCLES     4     consecutive equal samples required to accept a latch/clk level change (1..15)
//  LATCH_ACT_HIGH  1'b1  1: latch pin asserted high; 0: asserted low
//  TAIL_LEVEL      1'b0  line level driven after 8 bits (0 = host reads 1, as an official pad)
//  TURBO_POLLS     3     completed polls per turbo phase toggle (1..255)
//  BLOCK_OPPOSING  1'b1  1: Up+Down or Left+Right pressed together -> both reported released
// PORTS
//  clk_in          in   1  system clock (25 MHz)
//  rst_in          in   1  reset: synchronous, active-low
//  jp_latch_in     in   1  latch pin from host, asynchronous
//  jp_clk_in       in   1  clock pin from host, asynchronous, idles high
//  buttons_in      in   8  pressed=1; [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//  turbo_en_in     in   2  [0] turbo on A, [1] turbo on B
//  jp_data_out     out  1  data line level; pressed bit = 0
//  poll_strobe_out out  1  one-cycle pulse at accepted latch deassertion
//  bit_idx_out     out  4  bits already shifted out (0..8)
// BEHAVIOUR
//  - Reset (rst_in=0 at clk_in edge): state IDLE, shift reg 8'hFF (released), bit_idx 0,
//    jp_data_out=1, poll_strobe_out=0, turbo counter 0, turbo phase 0, filters preset: latch inactive, clk high.
//  - Inputs: 2-flop synchronizer then filter; filtered level changes after FILT_CYCLES equal samples.
//    Glitch shorter than FILT_CYCLES cycles never propagates. Pin edge -> filtered edge = 2+FILT_CYCLES cycles.
//  - Report: rpt = buttons_in; rpt[0] |= turbo_en_in[0]&phase; rpt[1] |= turbo_en_in[1]&phase
//    (turbo forces press only in phase 1, real press always wins); if BLOCK_OPPOSING clear
//    [4],[5] when both set, [6],[7] when both set. Shift reg holds ~rpt (active-low).
//  - FSM (filtered signals, latch = asserted level):
//    IDLE:  latch asserted -> LOAD. Data drives TAIL_LEVEL if a prior poll completed, else shreg[0].
//    LOAD:  shift reg reloaded with ~rpt every cycle; bit_idx=0; clk edges ignored.
//           latch deasserted -> SHIFT, poll_strobe_out=1 for that cycle, turbo counter++.
//    SHIFT: each filtered clk rising edge: shreg >>= 1 (fill with TAIL_LEVEL), bit_idx++.
//           bit_idx reaches 8 -> DONE. Latch asserted -> LOAD (abandoned poll, no error).
//    DONE:  data = TAIL_LEVEL; further clk edges ignored, bit_idx saturates at 8. Latch -> LOAD.
//  - jp_data_out registered = shreg[0] in LOAD/SHIFT; updates 1 cycle after filtered edge.
//  - Latch and clk edge in same cycle: latch wins (no shift).
//  - Turbo: counter 0..TURBO_POLLS-1; wraps to 0 and toggles phase on reaching TURBO_POLLS.
//  - buttons_in changes during SHIFT do not affect bits in flight; only LOAD samples.
//  - Reset mid-poll: all state back to reset values next edge; host sees 1s until next latch.
// STRUCTURE
//  - jp_pkg: button index constants (JP_A..JP_RIGHT), FSM state encoding (IDLE/LOAD/SHIFT/DONE, 2 bits).
//  - Sub-module jp_sync_filter (instanced twice: latch, clk): 2-flop sync + FILT_CYCLES counter,
//    params FILT_CYCLES, RESET_LEVEL; outputs level, rise, fall pulses.
//  - Top: report masking comb, FSM, shift reg, bit counter, turbo counter.
// TESTING
//  - Poll, buttons=8'h09 (A+Start): latch 12 us, 8 clk pulses 6 us -> host samples line 0,1,1,0,1,1,1,1;
//    9th+ sample = 0; poll_strobe_out one pulse; bit_idx_out ends 8.
//  - 2-cycle glitch on jp_clk_in mid-SHIFT (FILT=4) -> no shift, bit_idx_out unchanged.
//  - buttons=8'h30 (Up+Down), BLOCK_OPPOSING=1 -> bits 4,5 read line 1; with 0 -> line 0.
//  - turbo_en_in=2'b01, A released, TURBO_POLLS=3 -> A bit over 12 polls: 1,1,1,0,0,0,1,1,1,0,0,0.
//  - Latch reasserted after 3 clks -> reload; next poll starts from bit 0 with fresh buttons_in.
//  - rst_in=0 after 4 shifted bits -> jp_data_out=1, bit_idx_out=0 next cycle; next poll correct.

Source files
------------

// File: rtl/jp_pkg.sv
// jp_pkg: shared definitions for the NES joypad responder.
//   - Button bit positions inside the 8-bit report (A first on the wire).
//   - Responder FSM state encoding.
//   - Helper that releases opposing directions pressed together.
package jp_pkg;

    localparam int JP_A      = 0;
    localparam int JP_B      = 1;
    localparam int JP_SELECT = 2;
    localparam int JP_START  = 3;
    localparam int JP_UP     = 4;
    localparam int JP_DOWN   = 5;
    localparam int JP_LEFT   = 6;
    localparam int JP_RIGHT  = 7;

    localparam int JP_BITS   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } jp_state_e;

    // A physical d-pad cannot press both opposing directions; some games
    // crash when they see it, so both are reported released instead.
    function automatic logic [7:0] jp_mask_opposing(input logic [7:0] rpt);
        logic [7:0] r;
        r = rpt;
        if (rpt[JP_UP] && rpt[JP_DOWN]) begin
            r[JP_UP]   = 1'b0;
            r[JP_DOWN] = 1'b0;
        end
        if (rpt[JP_LEFT] && rpt[JP_RIGHT]) begin
            r[JP_LEFT]  = 1'b0;
            r[JP_RIGHT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/jp_sync_filter.sv
// jp_sync_filter: brings an asynchronous host pin into the clk_in domain and
// rejects glitches. The pin passes a 2-flop synchronizer, then the filtered
// level only changes once FILT_CYCLES consecutive synchronized samples
// disagree with it. Pin edge to filtered edge is 2+FILT_CYCLES cycles.
// Ports:
//   clk_in     in   system clock
//   rst_in     in   synchronous active-low reset (presets to RESET_LEVEL)
//   pin_in     in   asynchronous pin
//   level_out  out  filtered level
//   rise_out   out  one-cycle pulse when the filtered level goes 0->1
//   fall_out   out  one-cycle pulse when the filtered level goes 1->0
module jp_sync_filter #(
    parameter int   FILT_CYCLES = 4,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pin_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [3:0] cnt_q, cnt_d;

    // Any agreeing sample restarts the count, so a glitch shorter than
    // FILT_CYCLES never flips the level.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = 4'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == 4'(FILT_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out = level_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;

endmodule

// File: rtl/jp_responder.sv
// jp_responder: controller side of the NES joypad serial link, behaving like
// a 4021-based standard pad. The host drives latch and clock; the responder
// returns 8 active-low button bits (A first) on the data line.
// Ports:
//   clk_in           in   system clock
//   rst_in           in   synchronous active-low reset
//   jp_latch_in      in   host latch pin (asynchronous)
//   jp_clk_in        in   host clock pin (asynchronous, idles high)
//   buttons_in[7:0]  in   pressed=1, A,B,Select,Start,Up,Down,Left,Right
//   turbo_en_in[1:0] in   turbo enable for A (bit 0) and B (bit 1)
//   jp_data_out      out  data line, pressed bit = 0
//   poll_strobe_out  out  one-cycle pulse when a poll's latch is released
//   bit_idx_out[3:0] out  bits already shifted out (0..8)
module jp_responder
    import jp_pkg::*;
#(
    parameter int   FILT_CYCLES    = 4,
    parameter logic LATCH_ACT_HIGH = 1'b1,
    parameter logic TAIL_LEVEL     = 1'b0,
    parameter int   TURBO_POLLS    = 3,
    parameter logic BLOCK_OPPOSING = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       jp_latch_in,
    input  logic       jp_clk_in,
    input  logic [7:0] buttons_in,
    input  logic [1:0] turbo_en_in,
    output logic       jp_data_out,
    output logic       poll_strobe_out,
    output logic [3:0] bit_idx_out
);

    logic latch_level, latch_rise, latch_fall;
    logic clk_level, clk_rise, clk_fall;
    logic latch_act;
    logic unused_filt;

    jp_sync_filter #(
        .FILT_CYCLES (FILT_CYCLES),
        .RESET_LEVEL (~LATCH_ACT_HIGH)
    ) u_latch_filt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .pin_in    (jp_latch_in),
        .level_out (latch_level),
        .rise_out  (latch_rise),
        .fall_out  (latch_fall)
    );

    jp_sync_filter #(
        .FILT_CYCLES (FILT_CYCLES),
        .RESET_LEVEL (1'b1)
    ) u_clk_filt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .pin_in    (jp_clk_in),
        .level_out (clk_level),
        .rise_out  (clk_rise),
        .fall_out  (clk_fall)
    );

    // The FSM works on the latch level and the clk rising edge only.
    assign latch_act   = (latch_level == LATCH_ACT_HIGH);
    assign unused_filt = ^{latch_rise, latch_fall, clk_level, clk_fall};

    jp_state_e  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic       data_q, data_d;
    logic       strobe_q, strobe_d;
    logic [7:0] turbo_cnt_q, turbo_cnt_d;
    logic       phase_q, phase_d;
    logic [7:0] rpt;

    // Turbo only ever adds a press during phase 1; a real press always wins.
    always_comb begin
        rpt        = buttons_in;
        rpt[JP_A]  = buttons_in[JP_A] | (turbo_en_in[0] & phase_q);
        rpt[JP_B]  = buttons_in[JP_B] | (turbo_en_in[1] & phase_q);
        if (BLOCK_OPPOSING) begin
            rpt = jp_mask_opposing(rpt);
        end
    end

    // Latch has priority over a clk edge in the same cycle, so an abandoned
    // poll always reloads instead of shifting one last time.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        strobe_d    = 1'b0;
        turbo_cnt_d = turbo_cnt_q;
        phase_d     = phase_q;
        case (state_q)
            IDLE: begin
                if (latch_act) state_d = LOAD;
            end
            LOAD: begin
                shreg_d   = ~rpt;
                bit_idx_d = 4'd0;
                if (!latch_act) begin
                    state_d  = SHIFT;
                    strobe_d = 1'b1;
                    if (turbo_cnt_q == 8'(TURBO_POLLS - 1)) begin
                        turbo_cnt_d = 8'd0;
                        phase_d     = ~phase_q;
                    end else begin
                        turbo_cnt_d = turbo_cnt_q + 8'd1;
                    end
                end
            end
            SHIFT: begin
                if (latch_act) begin
                    state_d = LOAD;
                end else if (clk_rise) begin
                    shreg_d   = {TAIL_LEVEL, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd7) state_d = DONE;
                end
            end
            DONE: begin
                bit_idx_d = 4'd8;
                if (latch_act) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase

        // Line follows the shift register except once all 8 bits are out.
        // IDLE is only reachable from reset, so no poll has completed there.
        if (state_d == DONE) begin
            data_d = TAIL_LEVEL;
        end else begin
            data_d = shreg_d[0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            shreg_q     <= 8'hFF;
            bit_idx_q   <= 4'd0;
            data_q      <= 1'b1;
            strobe_q    <= 1'b0;
            turbo_cnt_q <= 8'd0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            turbo_cnt_q <= turbo_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign jp_data_out     = data_q;
    assign poll_strobe_out = strobe_q;
    assign bit_idx_out     = bit_idx_q;

endmodule

// File: tb/tb_jp_responder.sv
// tb_jp_responder: acts as the host console polling jp_responder.
// The host driver computes the expected line bits for each poll from the
// button/turbo rules and queues one entry per host sample; a separate
// monitor pops an entry whenever the host samples the data line and
// compares the line and bit index against it.
module tb_jp_responder;

    localparam int   FILT  = 4;
    localparam int   TP    = 3;
    localparam logic TAIL  = 1'b0;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       jp_latch_in;
    logic       jp_clk_in;
    logic [7:0] buttons_in;
    logic [1:0] turbo_en_in;
    logic       jp_data_out;
    logic       poll_strobe_out;
    logic [3:0] bit_idx_out;

    always #20 clk_in = ~clk_in;

    jp_responder #(
        .FILT_CYCLES    (FILT),
        .LATCH_ACT_HIGH (1'b1),
        .TAIL_LEVEL     (TAIL),
        .TURBO_POLLS    (TP),
        .BLOCK_OPPOSING (1'b1)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .jp_latch_in     (jp_latch_in),
        .jp_clk_in       (jp_clk_in),
        .buttons_in      (buttons_in),
        .turbo_en_in     (turbo_en_in),
        .jp_data_out     (jp_data_out),
        .poll_strobe_out (poll_strobe_out),
        .bit_idx_out     (bit_idx_out)
    );

    typedef struct {
        logic       exp_bit;
        logic [3:0] exp_idx;
        int         poll;
        int         slot;
    } sample_t;

    sample_t sb_q[$];
    event    sample_ev;

    int checks        = 0;
    int failures      = 0;
    int polls_done    = 0;
    int poll_id       = 0;
    int strobe_cycles = 0;
    int strobes_exp   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Expected active-low line pattern for a poll, from the pad rules:
    // turbo presses A/B during odd groups of TP polls, opposing dirs released.
    function automatic logic [7:0] model_line(input logic [7:0] btn,
                                              input logic [1:0] turbo,
                                              input int polls_before);
        logic [7:0] p;
        bit         phase;
        phase = ((polls_before / TP) % 2) == 1;
        p = btn;
        if (phase) p[1:0] = p[1:0] | turbo;
        if (p[4] && p[5]) begin p[4] = 1'b0; p[5] = 1'b0; end
        if (p[6] && p[7]) begin p[6] = 1'b0; p[7] = 1'b0; end
        return ~p;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic host_sample(input logic b, input logic [3:0] idx, input int slot);
        sample_t s;
        s.exp_bit = b;
        s.exp_idx = idx;
        s.poll    = poll_id;
        s.slot    = slot;
        sb_q.push_back(s);
        -> sample_ev;
    endtask

    // Monitor: compares the line whenever the host samples it.
    initial begin
        sample_t s;
        forever begin
            @(sample_ev);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard: got sample expected none queued");
            end else begin
                s = sb_q.pop_front();
                checkOutput($sformatf("poll%0d line slot%0d", s.poll, s.slot),
                            32'(jp_data_out), 32'(s.exp_bit));
                checkOutput($sformatf("poll%0d bit_idx slot%0d", s.poll, s.slot),
                            32'(bit_idx_out), 32'(s.exp_idx));
            end
        end
    end

    // Counts strobe cycles; a stretched strobe shows up as an extra count.
    always @(negedge clk_in) begin
        if (poll_strobe_out) strobe_cycles++;
    end

    // One host poll: latch pulse, then nclk clock pulses, sampling the line
    // before each pulse and once after the last one.
    task automatic applyStimulus(input logic [7:0] btn, input logic [1:0] turbo,
                                 input int latch_cyc, input int half, input int nclk,
                                 input int glitch_at, input bit scramble);
        logic [7:0] line;
        logic       b;
        logic [3:0] idx;
        buttons_in  = btn;
        turbo_en_in = turbo;
        line = model_line(btn, turbo, polls_done);
        poll_id++;
        jp_latch_in = 1'b1;
        wait_cycles(latch_cyc);
        jp_latch_in = 1'b0;
        polls_done++;
        strobes_exp++;
        wait_cycles(half);
        for (int k = 0; k <= nclk; k++) begin
            b   = (k < 8) ? line[k] : TAIL;
            idx = (k < 8) ? 4'(k) : 4'd8;
            host_sample(b, idx, k);
            if (scramble) begin
                buttons_in  = 8'($urandom);
                turbo_en_in = 2'($urandom);
            end
            if (k == glitch_at) begin
                jp_clk_in = 1'b0;
                wait_cycles(2);
                jp_clk_in = 1'b1;
                wait_cycles(half);
                host_sample(b, idx, 100 + k);
            end
            if (k < nclk) begin
                jp_clk_in = 1'b0;
                wait_cycles(half);
                jp_clk_in = 1'b1;
                wait_cycles(half);
            end
        end
        checkOutput($sformatf("poll%0d strobe cycles", poll_id),
                    32'(strobe_cycles), 32'(strobes_exp));
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        wait_cycles(2);
        rst_in = 1'b1;
        polls_done = 0;
        wait_cycles(2);
    endtask

    initial begin
        int nclk;
        int gl;
        rst_in      = 1'b0;
        jp_latch_in = 1'b0;
        jp_clk_in   = 1'b1;
        buttons_in  = 8'h00;
        turbo_en_in = 2'b00;
        wait_cycles(3);
        checkOutput("reset data", 32'(jp_data_out), 32'd1);
        checkOutput("reset bit_idx", 32'(bit_idx_out), 32'd0);
        checkOutput("reset strobe", 32'(poll_strobe_out), 32'd0);
        rst_in = 1'b1;
        wait_cycles(10);
        checkOutput("idle data", 32'(jp_data_out), 32'd1);

        $display("[TB] A+Start poll at console timing");
        applyStimulus(8'h09, 2'b00, 300, 150, 10, -1, 1'b0);

        $display("[TB] clk glitch mid-shift");
        applyStimulus(8'hA5, 2'b00, 12, 10, 8, 3, 1'b0);

        $display("[TB] opposing directions");
        applyStimulus(8'h30, 2'b00, 12, 10, 8, -1, 1'b0);
        applyStimulus(8'hC0, 2'b00, 12, 10, 8, -1, 1'b0);

        $display("[TB] turbo on A over 12 polls");
        do_reset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'h00, 2'b01, 12, 10, 8, -1, 1'b0);
        end

        $display("[TB] abandoned poll then fresh poll");
        applyStimulus(8'h81, 2'b00, 12, 10, 3, -1, 1'b0);
        applyStimulus(8'h42, 2'b00, 12, 10, 8, -1, 1'b0);

        $display("[TB] reset mid-poll");
        applyStimulus(8'h5A, 2'b00, 12, 10, 4, -1, 1'b0);
        rst_in = 1'b0;
        wait_cycles(1);
        checkOutput("mid-poll reset data", 32'(jp_data_out), 32'd1);
        checkOutput("mid-poll reset bit_idx", 32'(bit_idx_out), 32'd0);
        rst_in = 1'b1;
        polls_done = 0;
        wait_cycles(5);
        host_sample(1'b1, 4'd0, 200);
        applyStimulus(8'h24, 2'b00, 12, 10, 9, -1, 1'b0);

        $display("[TB] randomized polls");
        for (int i = 0; i < 30; i++) begin
            nclk = ($urandom_range(0, 9) == 0) ? 3 : 8 + int'($urandom_range(0, 2));
            gl   = int'($urandom_range(0, 12));
            applyStimulus(8'($urandom), 2'($urandom_range(0, 3)), 12, 10, nclk, gl, 1'b1);
        end

        wait_cycles(5);
        checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
